// File: rtl/dec_2to4.sv
// dec_2to4: 2-to-4 one-hot decoder with enable, plus a registered copy and valid flag
`timescale 1ns/1ps
module dec_2to4 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] S,
    input  logic       En,
    output logic [0:3] Y,
    output logic [0:3] Y_r,
    output logic       valid_r
);
    // Y[0] is the MSB, so shifting a single MSB one-hot right by S lands on Y[S]; En is tested first so an unknown S never reaches Y while disabled
    always_comb Y = En ? 4'b1000 >> S : 4'b0000;
    // Registered copy of the decode and enable, cleared at once by reset
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            Y_r     <= 4'b0000;
            valid_r <= 1'b0;
        end else begin
            Y_r     <= Y;
            valid_r <= En;
        end
endmodule

// File: tb/tb_dec_2to4.sv
// tb_dec_2to4: directed and random checks of dec_2to4 with a scoreboard for the registered path
`timescale 1ns/1ps
module tb_dec_2to4;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] S = 2'd0;
    logic       En = 1'b0;
    logic [0:3] Y, Y_r;
    logic       valid_r;
    bit         run = 1'b0;
    int         errors = 0;
    int         checks = 0;
    logic [4:0] sb_q[$];
    logic [3:0] lut[4] = '{4'd8, 4'd4, 4'd2, 4'd1};

    dec_2to4 dut (.clk(clk), .rst(rst), .S(S), .En(En), .Y(Y), .Y_r(Y_r), .valid_r(valid_r));

    always begin
        #5;
        if (run) clk = ~clk;
    end

    task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %b, want %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_reg();
        sb_q.push_back({En, En ? lut[S] : 4'd0});
    endtask

    task automatic pop_reg(input string tag);
        logic [4:0] e;
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 5'd1, 5'd0);
        end else begin
            e = sb_q.pop_front();
            chk(tag, {valid_r, Y_r}, e);
        end
    endtask

    initial begin
        #1 rst = 1'b1;
        #1;
        chk("reset_Y_r", {1'b0, Y_r}, 5'd0);
        chk("reset_valid", {4'd0, valid_r}, 5'd0);
        En = 1'b1;
        for (int k = 0; k < 4; k++) begin
            S = 2'(k);
            #10;
            chk($sformatf("en_sweep_S%0d", k), {1'b0, Y}, {1'b0, lut[k]});
        end
        En = 1'b0;
        S = 2'bxx;
        #10;
        chk("dis_Sx", {1'b0, Y}, 5'd0);
        for (int k = 0; k < 4; k++) begin
            S = 2'(k);
            #10;
            chk($sformatf("dis_sweep_S%0d", k), {1'b0, Y}, 5'd0);
        end
        En = 1'b1;
        S = 2'd3;
        #1;
        chk("reenable_S3", {1'b0, Y}, 5'd1);
        En = 1'b0;
        #1 rst = 1'b0;
        run = 1'b1;
        En = 1'b1;
        S = 2'd1;
        push_reg();
        tick();
        pop_reg("reg_S1");
        En = 1'b0;
        push_reg();
        tick();
        pop_reg("reg_dis");
        En = 1'b1;
        S = 2'd2;
        push_reg();
        tick();
        pop_reg("reg_S2");
        #2 rst = 1'b1;
        #1;
        chk("async_rst_reg", {valid_r, Y_r}, 5'd0);
        chk("async_rst_Y", {1'b0, Y}, 5'd2);
        tick();
        chk("rst_hold_reg", {valid_r, Y_r}, 5'd0);
        rst = 1'b0;
        for (int i = 0; i < 220; i++) begin
            S = 2'($urandom_range(0, 3));
            En = 1'($urandom_range(0, 1));
            #1;
            chk("rnd_onehot", {4'd0, 1'($countones(Y) <= 1)}, 5'd1);
            chk("rnd_Y", {1'b0, Y}, {1'b0, En ? lut[S] : 4'd0});
            push_reg();
            tick();
            pop_reg("rnd_reg");
        end
        run = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dec_2to4.md
# dec_2to4

Two-to-four line decoder with active-high enable, plus a registered copy of the decoded word and a valid flag. It drives one of four one-hot select lines from a 2-bit code and serves as the basic select-line generator for wider decoder trees and chip-select logic. The combinational output responds without a clock. The registered outputs give downstream synchronous logic a clean, glitch-free version one cycle later.

## Interface
Parameters:
- None. Widths are fixed: 2-bit select, 4-bit one-hot output.

Ports:
- clk  input  1  system clock; registered outputs update on the rising edge.
- rst  input  1  reset, asynchronous and active-high; clears all registered outputs.
- S  input  2  select code, unsigned 0..3.
- En  input  1  active-high enable.
- Y  output  4, declared [0:3]  combinational one-hot decode. Y[0] is the MSB of the vector.
- Y_r  output  4, declared [0:3]  registered copy of Y.
- valid_r  output  1  registered copy of En. High means Y_r holds a live decode.

## Operation
- The combinational decode sets Y[k] = 1 exactly when En = 1 and S = k, for k = 0..3.
- Because Y[0] is the MSB, the 4-bit value of Y is:
  - S = 0 -> 4'b1000 (8)
  - S = 1 -> 4'b0100 (4)
  - S = 2 -> 4'b0010 (2)
  - S = 3 -> 4'b0001 (1)
- When En = 0, Y = 4'b0000 regardless of S.
  - This holds even when S is X or Z.
  - Enable gating must dominate: AND each term with En, or test !En first. No X may propagate to Y while En = 0.
- When En = 1 and S is X or Z, Y is don't-care in simulation. Synthesis has no such case.
- With En = 1, at most one bit of Y is high at any time. This is the one-hot invariant.
- Registered path: on each rising clk edge, Y_r <= Y and valid_r <= En.
- The block holds no other state and has no state machine.

## Timing
- Y is purely combinational from S and En, with zero cycle latency. It does not depend on clk or rst, and it is valid during reset.
- Y_r and valid_r have one-cycle latency. They reflect the S and En sampled at the previous rising edge.
- Reset values: Y_r = 4'b0000 and valid_r = 0.
  - Both clear immediately when rst asserts, with no clock edge needed.
  - Both hold those values while rst = 1.
- The first rising edge after rst deasserts captures the current decode.
- Reset asserted mid-operation clears Y_r and valid_r at once. Y keeps following its inputs.
- Same-edge input changes: a change to S or En coincident with a clock edge is captured at the following edge. Standard setup and hold timing applies.
- Y_r is never multi-hot. It is always either zero or a single one-hot bit.

## Test plan
1. Enabled sweep: En = 1, S = 0,1,2,3 held 10 time units each -> Y = 8, 4, 2, 1 respectively. Check this with no clock running.
2. Disable with unknown select: En = 0, S = 2'bx -> Y = 0, with no X on any bit of Y.
3. Disable sweep: En = 0, S = 0..3 -> Y = 0 for every value. Then raise En = 1 with S = 3 -> Y = 1 immediately.
4. Registered path: rst pulse, then clock with En = 1 and S = 1 -> Y_r = 4 and valid_r = 1 one edge later. Then drive En = 0 -> Y_r = 0 and valid_r = 0 after the next edge.
5. Asynchronous reset mid-run: with Y_r = 2 and valid_r = 1, assert rst between clock edges -> Y_r = 0 and valid_r = 0 immediately, while Y is unchanged (still 2).
6. Invariant check: random S and En over at least 200 cycles -> Y is always one-hot or zero, Y is zero whenever En = 0, and Y_r equals the previous-cycle Y.
